if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Consumes the current PC and issues one word read per instruction to instruction memory with a req/ack handshake.
- Latches the word into an instruction register (IR) and offers it to decode with a valid/ready handshake.
- Drives `pc_hold`, the PC register's load-inhibit (1 = hold), so the PC advances exactly once per consumed instruction or redirect.

Parameters:
- IMEM_BASE, 32'h00400000, byte address of instruction memory word 0.
- ADDR_W, 11, instruction memory word-address width (2048 words).
- TIMEOUT_CYCLES, 255, maximum REQ cycles before a timeout fault; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  rising-edge clock; the PC register samples `pc_hold` on the falling edge of the same clock.
- reset  in  1  asynchronous, active-high.
- pc_in  in  32  current PC from the PC register.
- imem_req  out  1  read request; held high until acked.
- imem_addr  out  ADDR_W  word address, (pc - IMEM_BASE) >> 2; stable while imem_req is high.
- imem_ack  in  1  memory has returned data; sampled on the rising edge while imem_req = 1.
- imem_rdata  in  32  read data, valid with imem_ack.
- flush  in  1  redirect pulse; the PC register loads the new target during this cycle.
- ir_valid  out  1  IR holds an instruction for decode.
- ir_ready  in  1  decode accepts the IR.
- ir_instr  out  32  latched instruction.
- ir_pc  out  32  PC of ir_instr.
- pc_hold  out  1  1 = PC register holds; drives the PC's load-inhibit input.
- fault  out  1  sticky fetch fault.
- fault_code  out  2  01 misaligned, 11 out of range, 10 timeout, 00 none.

Behaviour:
- Reset (async):
  - state = IDLE.
  - imem_req, imem_addr, ir_valid, ir_instr, ir_pc, fault and fault_code = 0.
  - Drop flag cleared; timeout counter = 0.
- States: IDLE, REQ, FULL, FAULT.
- IDLE:
  - If pc_in[1:0] != 0: go to FAULT with code 01.
  - Else if pc_in < IMEM_BASE or the word index is ≥ 2^ADDR_W: go to FAULT with code 11.
  - Else: register imem_req = 1, imem_addr, and fetch_pc = pc_in; go to REQ.
- REQ:
  - imem_req stays high and imem_addr is held.
  - On imem_ack with the drop flag clear: ir_instr = imem_rdata, ir_pc = fetch_pc, ir_valid = 1, imem_req = 0; go to FULL.
  - On imem_ack with the drop flag set: discard the data, clear the flag, imem_req = 0; go to IDLE.
  - flush in REQ without ack sets the drop flag.
  - flush in the same cycle as ack discards the data and goes to IDLE.
- FULL:
  - A handshake (ir_valid & ir_ready at the rising edge) clears ir_valid; go to IDLE.
  - flush clears ir_valid; go to IDLE. flush has priority over the handshake.
- FAULT:
  - Stays until reset or flush; imem_req = 0, fault = 1.
  - flush clears fault and fault_code; go to IDLE.
- pc_hold is combinational: pc_hold = !(flush | (state == FULL & ir_ready)).
  - The PC therefore updates on the falling edge inside a handshake or flush cycle.
  - IDLE samples the new PC on the next rising edge.
  - The PC never moves during IDLE, REQ, or FAULT without flush.
- Latency and throughput:
  - Zero-wait memory (ack during the first REQ cycle): ir_valid rises 2 edges after entering IDLE.
  - Steady state is 1 instruction per 3 cycles; each memory wait state adds 1 cycle.
- Only one request is ever outstanding.
- The first fetch after reset release uses pc_in = 0x00400000, giving imem_addr = 0.

Optional Feature:
- FETCH_TIMEOUT_EN defined:
  - A counter runs while in REQ; it clears on entering REQ.
  - At TIMEOUT_CYCLES without ack: imem_req = 0, go to FAULT with code 10.
  - A late ack after that point is ignored.
- FETCH_TIMEOUT_EN undefined: REQ waits indefinitely, and code 10 is never produced.

Decomposition:
- Shared package if_pkg holds:
  - the state enum (IDLE/REQ/FULL/FAULT);
  - fault code constants FC_NONE, FC_MISALIGN, FC_TIMEOUT, FC_RANGE;
  - default IMEM_BASE.
- One sub-module is natural: if_watchdog, the timeout counter, instantiated only under FETCH_TIMEOUT_EN.

Test Plan:
- Reset with pc_in = 0x00400000 and zero-wait memory: imem_req = 1 and imem_addr = 0 after the first edge; ir_valid = 1 two edges later. With ir_ready = 1, pc_hold = 0 in exactly that cycle.
- pc_in = 0x00400010 with ack delayed 3 cycles: imem_addr = 4 held for 3 cycles, then ir_instr = rdata and ir_pc = 0x00400010. With ir_ready = 0 for 5 cycles, pc_hold stays 1 throughout.
- flush during REQ, then ack 2 cycles later: ir_valid stays 0 and the data is discarded. The next request uses the redirected pc_in (e.g. 0x00400100, giving addr 0x40).
- flush and handshake in the same FULL cycle: ir_valid = 0, state = IDLE, pc_hold = 0 for one cycle only.
- pc_in = 0x00400002: no request, fault = 1, fault_code = 01, pc_hold = 1. pc_in = 0x00000000 gives fault_code = 11. A subsequent flush clears the fault.
- With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES = 4, no ack: imem_req drops after 4 cycles, fault_code = 10, and a later ack leaves ir_valid = 0.

Source files
------------

// File: rtl/if_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg
//
// Shared definitions for the instruction-fetch stage:
//   - fetch_state_t : fetch FSM states (IDLE, REQ, FULL, FAULT)
//   - FC_*          : fault_code encodings reported on if_fetch_unit.fault_code
//   - IMEM_BASE_DEFAULT : default byte address of instruction memory word 0
// -----------------------------------------------------------------------------
package if_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FULL  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;
    localparam logic [1:0] FC_RANGE    = 2'b11;

    localparam logic [31:0] IMEM_BASE_DEFAULT = 32'h0040_0000;

endpackage

// File: rtl/if_watchdog.sv
// -----------------------------------------------------------------------------
// if_watchdog
//
// Counts consecutive cycles spent waiting on an instruction-memory request and
// flags the cycle in which the wait reaches TIMEOUT_CYCLES. Only instantiated
// by if_fetch_unit when FETCH_TIMEOUT_EN is defined.
//
// Ports:
//   clk      in  rising-edge clock
//   reset    in  asynchronous, active-high
//   run      in  1 while the fetch FSM is in REQ; 0 clears the count
//   expired  out 1 during the TIMEOUT_CYCLES-th consecutive REQ cycle
// -----------------------------------------------------------------------------
module if_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // The count sits at zero outside REQ, so every new request starts from a
    // clean count on its first REQ cycle. It never needs to wrap: the FSM
    // leaves REQ in the cycle that expired is raised.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (run) begin
            count <= count + CW'(1);
        end else begin
            count <= '0;
        end
    end

    assign expired = run && (count == LAST);

endmodule

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage sitting directly behind the PC register. For each
// instruction it checks the PC, issues a single word read to instruction
// memory (req/ack), latches the returned word into the instruction register
// and offers it to decode (valid/ready). pc_hold inhibits the PC register so
// the PC advances exactly once per consumed instruction or redirect.
//
// Optional build macro:
//   FETCH_TIMEOUT_EN : when defined, a request left unacknowledged for
//                      TIMEOUT_CYCLES cycles is abandoned and the unit faults
//                      with code 10. When undefined, REQ waits indefinitely.
//
// Ports:
//   clk         in  rising-edge clock (PC register samples pc_hold on falling edge)
//   reset       in  asynchronous, active-high
//   pc_in       in  current PC from the PC register
//   imem_req    out read request, held until acked
//   imem_addr   out word address (pc - IMEM_BASE) >> 2, stable while imem_req
//   imem_ack    in  read data valid, sampled while imem_req = 1
//   imem_rdata  in  read data
//   flush       in  redirect pulse; PC loads its new target this cycle
//   ir_valid    out IR holds an instruction for decode
//   ir_ready    in  decode accepts the IR
//   ir_instr    out latched instruction
//   ir_pc       out PC of ir_instr
//   pc_hold     out 1 = PC register holds
//   fault       out sticky fetch fault
//   fault_code  out 01 misaligned, 11 out of range, 10 timeout, 00 none
// -----------------------------------------------------------------------------
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] IMEM_BASE      = IMEM_BASE_DEFAULT,
    parameter int          ADDR_W         = 11,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pc_in,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              flush,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [31:0]       ir_instr,
    output logic [31:0]       ir_pc,
    output logic              pc_hold,
    output logic              fault,
    output logic [1:0]        fault_code
);

    fetch_state_t state, state_next;

    logic [31:0]       fetch_pc, fetch_pc_next;
    logic              drop, drop_next;
    logic              req_next;
    logic [ADDR_W-1:0] addr_next;
    logic              valid_next;
    logic [31:0]       instr_next;
    logic [31:0]       ir_pc_next;
    logic              fault_next;
    logic [1:0]        code_next;

    logic              pc_misaligned;
    logic              pc_out_of_range;
    logic [29:0]       word_index;
    logic              in_req;
    logic              timeout_hit;

    // PC legality. word_index is only meaningful when pc_in >= IMEM_BASE; the
    // range test rejects anything below the base before the index is trusted.
    assign word_index      = 30'((pc_in - IMEM_BASE) >> 2);
    assign pc_misaligned   = (pc_in[1:0] != 2'b00);
    assign pc_out_of_range = (pc_in < IMEM_BASE) || ((word_index >> ADDR_W) != '0);

    assign in_req = (state == REQ);

`ifdef FETCH_TIMEOUT_EN
    if_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .run     (in_req),
        .expired (timeout_hit)
    );
`else
    // No watchdog in this build; the parameter is still referenced so both
    // builds present the same parameter list without an unused-parameter hole.
    assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    // The PC register loads on the falling edge, so releasing it inside a
    // handshake or flush cycle makes the new PC visible to IDLE on the very
    // next rising edge.
    assign pc_hold = !(flush || ((state == FULL) && ir_ready));

    // State and all datapath registers. Everything the FSM owns is computed
    // in the next-state block below and simply registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            imem_req   <= 1'b0;
            imem_addr  <= '0;
            fetch_pc   <= '0;
            drop       <= 1'b0;
            ir_valid   <= 1'b0;
            ir_instr   <= '0;
            ir_pc      <= '0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
        end else begin
            state      <= state_next;
            imem_req   <= req_next;
            imem_addr  <= addr_next;
            fetch_pc   <= fetch_pc_next;
            drop       <= drop_next;
            ir_valid   <= valid_next;
            ir_instr   <= instr_next;
            ir_pc      <= ir_pc_next;
            fault      <= fault_next;
            fault_code <= code_next;
        end
    end

    // Next-state and next-register values. Every register holds by default;
    // each state only overrides what it changes.
    always_comb begin
        state_next    = state;
        req_next      = imem_req;
        addr_next     = imem_addr;
        fetch_pc_next = fetch_pc;
        drop_next     = drop;
        valid_next    = ir_valid;
        instr_next    = ir_instr;
        ir_pc_next    = ir_pc;
        fault_next    = fault;
        code_next     = fault_code;

        unique case (state)
            IDLE: begin
                // A flush seen here needs no action: the PC has already loaded
                // its target on the falling edge, so pc_in is the new PC.
                if (pc_misaligned) begin
                    fault_next = 1'b1;
                    code_next  = FC_MISALIGN;
                    state_next = FAULT;
                end else if (pc_out_of_range) begin
                    fault_next = 1'b1;
                    code_next  = FC_RANGE;
                    state_next = FAULT;
                end else begin
                    req_next      = 1'b1;
                    addr_next     = word_index[ADDR_W-1:0];
                    fetch_pc_next = pc_in;
                    state_next    = REQ;
                end
            end

            REQ: begin
                // The request already in flight cannot be cancelled at the
                // memory, so a redirect only marks its data as unwanted.
                if (imem_ack) begin
                    req_next  = 1'b0;
                    drop_next = 1'b0;
                    if (drop || flush) begin
                        state_next = IDLE;
                    end else begin
                        instr_next = imem_rdata;
                        ir_pc_next = fetch_pc;
                        valid_next = 1'b1;
                        state_next = FULL;
                    end
                end else if (timeout_hit) begin
                    req_next   = 1'b0;
                    drop_next  = 1'b0;
                    fault_next = 1'b1;
                    code_next  = FC_TIMEOUT;
                    state_next = FAULT;
                end else if (flush) begin
                    drop_next = 1'b1;
                end
            end

            FULL: begin
                // Flush and handshake both empty the IR; which one fired only
                // matters to the PC register, which pc_hold already handles.
                if (flush || ir_ready) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end

            FAULT: begin
                if (flush) begin
                    fault_next = 1'b0;
                    code_next  = FC_NONE;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Self-checking bench for if_fetch_unit. The bench plays the PC register
// (falling-edge load, +4 or flush target) and instruction memory (word value
// derived from the word address). Covers: reset state, a table of PC
// legality vectors, hand-written multi-cycle sequences, the optional timeout
// (FETCH_TIMEOUT_EN) and a randomized run against a transaction-level model.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam logic [31:0] BASE = 32'h0040_0000;
    localparam int          AW   = 11;

    logic          clk;
    logic          reset;
    logic [31:0]   pc_in;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          flush;
    logic          ir_valid;
    logic          ir_ready;
    logic [31:0]   ir_instr;
    logic [31:0]   ir_pc;
    logic          pc_hold;
    logic          fault;
    logic [1:0]    fault_code;

    logic [31:0]   flush_target;
    int            n_compared;
    int            n_mismatched;

    if_fetch_unit #(
        .IMEM_BASE      (BASE),
        .ADDR_W         (AW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_in      (pc_in),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .flush      (flush),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .ir_instr   (ir_instr),
        .ir_pc      (ir_pc),
        .pc_hold    (pc_hold),
        .fault      (fault),
        .fault_code (fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        logic [31:0] wide;
        wide = {21'd0, a};
        return 32'hC0DE_0000 ^ (wide * 32'h9E37_79B1);
    endfunction

    function automatic logic [AW-1:0] word_of(input logic [31:0] pc);
        logic [31:0] off;
        off = (pc - BASE) >> 2;
        return off[AW-1:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
        end
    endtask

    // Drive this cycle's inputs (called just after a rising edge) and let the
    // combinational outputs settle.
    task automatic applyStimulus(input logic f, input logic [31:0] tgt,
                                 input logic rdy, input logic ack,
                                 input logic [31:0] rd);
        flush        = f;
        flush_target = tgt;
        ir_ready     = rdy;
        imem_ack     = ack;
        imem_rdata   = rd;
        #1;
    endtask

    // One clock: the PC register acts on the falling edge, then the DUT's
    // rising edge; returns 1 time unit after that edge.
    task automatic tick();
        @(negedge clk);
        if (flush)
            pc_in = flush_target;
        else if (!pc_hold)
            pc_in = pc_in + 32'd4;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input logic [31:0] pc, input logic check);
        reset = 1'b1;
        pc_in = pc;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        if (check) begin
            checkOutput("rst_imem_req",   imem_req,   0);
            checkOutput("rst_imem_addr",  imem_addr,  0);
            checkOutput("rst_ir_valid",   ir_valid,   0);
            checkOutput("rst_ir_instr",   ir_instr,   0);
            checkOutput("rst_ir_pc",      ir_pc,      0);
            checkOutput("rst_fault",      fault,      0);
            checkOutput("rst_fault_code", fault_code, 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic [31:0]   pc;
        logic          exp_req;
        logic [AW-1:0] exp_addr;
        logic          exp_fault;
        logic [1:0]    exp_code;
    } idle_vec_t;

    idle_vec_t vecs[10];

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: bench still running, required to finish");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset        = 1'b1;
        pc_in        = BASE;
        flush        = 1'b0;
        flush_target = '0;
        ir_ready     = 1'b0;
        imem_ack     = 1'b0;
        imem_rdata   = '0;

        // PC legality: one edge out of IDLE decides request vs fault.
        vecs[0] = '{32'h0040_0000, 1'b1, 11'd0,    1'b0, 2'b00};
        vecs[1] = '{32'h0040_0010, 1'b1, 11'd4,    1'b0, 2'b00};
        vecs[2] = '{32'h0040_1FFC, 1'b1, 11'd2047, 1'b0, 2'b00};
        vecs[3] = '{32'h0040_0100, 1'b1, 11'h040,  1'b0, 2'b00};
        vecs[4] = '{32'h0040_2000, 1'b0, 11'd0,    1'b1, 2'b11};
        vecs[5] = '{32'h0000_0000, 1'b0, 11'd0,    1'b1, 2'b11};
        vecs[6] = '{32'h003F_FFFC, 1'b0, 11'd0,    1'b1, 2'b11};
        vecs[7] = '{32'h0040_0002, 1'b0, 11'd0,    1'b1, 2'b01};
        vecs[8] = '{32'h0040_0001, 1'b0, 11'd0,    1'b1, 2'b01};
        vecs[9] = '{32'hFFFF_FFFF, 1'b0, 11'd0,    1'b1, 2'b01};

        @(posedge clk);
        #1;
        doReset(BASE, 1'b0);

        for (int i = 0; i < 10; i++) begin
            doReset(vecs[i].pc, 1'b0);
            tick();
            checkOutput($sformatf("vec%0d_req", i),   imem_req,   vecs[i].exp_req);
            checkOutput($sformatf("vec%0d_addr", i),  imem_addr,  vecs[i].exp_addr);
            checkOutput($sformatf("vec%0d_fault", i), fault,      vecs[i].exp_fault);
            checkOutput($sformatf("vec%0d_code", i),  fault_code, vecs[i].exp_code);
            checkOutput($sformatf("vec%0d_hold", i),  pc_hold,    1);
        end

        // Zero-wait fetch from reset, consume, and the next request 3 edges on.
        doReset(BASE, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        tick();
        checkOutput("s1_req",  imem_req,  1);
        checkOutput("s1_addr", imem_addr, 0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h1111_2222);
        checkOutput("s1_hold_req", pc_hold, 1);
        tick();
        checkOutput("s1_valid", ir_valid, 1);
        checkOutput("s1_instr", ir_instr, 32'h1111_2222);
        checkOutput("s1_ir_pc", ir_pc,    BASE);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        checkOutput("s1_hold_hs", pc_hold, 0);
        tick();
        checkOutput("s1_valid_after", ir_valid, 0);
        checkOutput("s1_hold_idle",   pc_hold,  1);
        tick();
        checkOutput("s1_next_req",  imem_req,  1);
        checkOutput("s1_next_addr", imem_addr, 1);

        // Asynchronous reset mid-cycle clears everything, including the IR.
        doReset(BASE + 32'h10, 1'b1);

        // Three wait states, then a stalled decode for five cycles.
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("s2_req_w%0d", i),  imem_req,  1);
            checkOutput($sformatf("s2_addr_w%0d", i), imem_addr, 4);
            tick();
        end
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'hCAFE_F00D);
        checkOutput("s2_addr_ack", imem_addr, 4);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        checkOutput("s2_instr", ir_instr, 32'hCAFE_F00D);
        checkOutput("s2_ir_pc", ir_pc,    BASE + 32'h10);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("s2_stall_hold%0d", i),  pc_hold,  1);
            checkOutput($sformatf("s2_stall_valid%0d", i), ir_valid, 1);
            tick();
        end

        // Flush during REQ; the ack two cycles later is discarded.
        doReset(BASE, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        tick();
        applyStimulus(1'b1, BASE + 32'h100, 1'b0, 1'b0, 32'd0);
        checkOutput("s3_hold_flush", pc_hold, 0);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h1234_5678);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        checkOutput("s3_dropped_valid", ir_valid, 0);
        checkOutput("s3_dropped_req",   imem_req, 0);
        tick();
        checkOutput("s3_redir_req",  imem_req,  1);
        checkOutput("s3_redir_addr", imem_addr, 11'h040);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'hA0A0_0100);
        tick();
        checkOutput("s3_redir_valid", ir_valid, 1);
        checkOutput("s3_redir_ir_pc", ir_pc,    BASE + 32'h100);

        // Flush and handshake together in FULL: flush target wins.
        applyStimulus(1'b1, BASE + 32'h200, 1'b1, 1'b0, 32'd0);
        checkOutput("s4_hold_both", pc_hold, 0);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        checkOutput("s4_valid", ir_valid, 0);
        checkOutput("s4_req",   imem_req, 0);
        checkOutput("s4_hold_after", pc_hold, 1);
        tick();
        checkOutput("s4_addr", imem_addr, 11'h080);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h5555_AAAA);
        tick();
        checkOutput("s4_ir_pc", ir_pc, BASE + 32'h200);

        // Faults are sticky and cleared only by flush.
        doReset(BASE + 32'h2, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        tick();
        tick();
        tick();
        checkOutput("s5_mis_fault", fault,      1);
        checkOutput("s5_mis_code",  fault_code, 2'b01);
        checkOutput("s5_mis_req",   imem_req,   0);
        checkOutput("s5_mis_hold",  pc_hold,    1);
        applyStimulus(1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'd0);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        checkOutput("s5_clear_fault", fault,      0);
        checkOutput("s5_clear_code",  fault_code, 2'b00);
        tick();
        checkOutput("s5_rng_code", fault_code, 2'b11);
        applyStimulus(1'b1, BASE, 1'b0, 1'b0, 32'd0);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        tick();
        checkOutput("s5_recover_req",   imem_req, 1);
        checkOutput("s5_recover_fault", fault,    0);

`ifdef FETCH_TIMEOUT_EN
        // Timeout after 4 unacknowledged REQ cycles; a late ack is ignored.
        doReset(BASE, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("to_req_%0d", i), imem_req, 1);
            tick();
        end
        checkOutput("to_req_3", imem_req, 1);
        tick();
        checkOutput("to_req_drop", imem_req,   0);
        checkOutput("to_fault",    fault,      1);
        checkOutput("to_code",     fault_code, 2'b10);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h0BAD_0BAD);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        checkOutput("to_late_valid", ir_valid,   0);
        checkOutput("to_late_code",  fault_code, 2'b10);
`else
        // Without the watchdog a request waits as long as memory takes.
        doReset(BASE, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 300; i++) tick();
        checkOutput("nowd_req",   imem_req,   1);
        checkOutput("nowd_fault", fault,      0);
        checkOutput("nowd_code",  fault_code, 2'b00);
`endif

        // Randomized run against a transaction-level model: delivered
        // instructions must follow the program order implied by flushes,
        // carry the memory word of their own PC, and discard any fetch that
        // a flush overtook.
        begin
            logic [31:0]   exp_pc;
            logic          mvalid;
            logic          tainted;
            logic          req_seen;
            logic [AW-1:0] held_addr;
            int            wait_left;
            int            delivered;
            logic          f;
            logic          rdy;
            logic          ack;
            logic [31:0]   tgt;
            logic [31:0]   rd;

            doReset(BASE, 1'b0);
            exp_pc    = BASE;
            mvalid    = 1'b0;
            tainted   = 1'b0;
            req_seen  = 1'b0;
            held_addr = '0;
            wait_left = 0;
            delivered = 0;

            for (int cyc = 0; cyc < 600; cyc++) begin
                checkOutput("rnd_ir_valid", ir_valid, mvalid);
                ack = 1'b0;
                rd  = $urandom;
                if (imem_req) begin
                    if (!req_seen) begin
                        held_addr = word_of(pc_in);
                        checkOutput("rnd_addr_issue", imem_addr, held_addr);
                        req_seen  = 1'b1;
                        tainted   = 1'b0;
                        wait_left = $urandom_range(0, 3);
                    end else begin
                        checkOutput("rnd_addr_held", imem_addr, held_addr);
                    end
                    if (wait_left == 0) begin
                        ack      = 1'b1;
                        rd       = mem_word(held_addr);
                        req_seen = 1'b0;
                    end else begin
                        wait_left--;
                    end
                end else begin
                    req_seen = 1'b0;
                end

                f   = ($urandom_range(0, 15) == 0);
                tgt = BASE + (32'($urandom_range(0, 1800)) << 2);
                rdy = ($urandom_range(0, 3) != 0);
                applyStimulus(f, tgt, rdy, ack, rd);

                checkOutput("rnd_pc_hold", pc_hold, !(f || (mvalid && rdy)));
                if (imem_req && f) tainted = 1'b1;

                if (f) begin
                    exp_pc = tgt;
                    mvalid = 1'b0;
                end else if (mvalid && rdy) begin
                    checkOutput("rnd_ir_pc",    ir_pc,    exp_pc);
                    checkOutput("rnd_ir_instr", ir_instr, mem_word(word_of(exp_pc)));
                    exp_pc    = exp_pc + 32'd4;
                    mvalid    = 1'b0;
                    delivered++;
                end
                if (ack && !tainted) mvalid = 1'b1;

                tick();
            end
            checkOutput("rnd_progress", (delivered >= 20), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
